// File: rtl/dds_pkg.sv
// Shared constants, FSM state type and operand helper for the DDS skew-constant scheduler.
package dds_pkg;

    localparam int unsigned DDS_CONST_W       = 18;
    localparam int unsigned DDS_SKEW_W        = 16;
    // Numerator is 2^DDS_NUM_LIMIT_BIT; quotients satisfy den*q < 2^27.
    localparam int unsigned DDS_NUM_LIMIT_BIT = 27;

    typedef enum logic [1:0] {
        StIdle,
        StDiv1,
        StDiv2,
        StWrite
    } dds_state_e;

    // (2^18 - d) mod 2^18, the denominator for Y3.
    function automatic logic [DDS_CONST_W-1:0] dds_complement(input logic [DDS_CONST_W-1:0] d);
        return (~d) + 1'b1;
    endfunction

endpackage

// File: rtl/dds_const_sched_if.sv
// Channel-side bundle of the skew-constant scheduler: skew/update in, constants out.
interface dds_const_sched_if #(
    parameter int unsigned N = 12
);

    logic [dds_pkg::DDS_SKEW_W*N-1:0]  Skew;
    logic [N-1:0]                      Update;
    logic [dds_pkg::DDS_CONST_W*N-1:0] Y1;
    logic [dds_pkg::DDS_CONST_W*N-1:0] Y2;
    logic [dds_pkg::DDS_CONST_W*N-1:0] Y3;
    logic [N-1:0]                      Valid;
    logic [N-1:0]                      Done;
    logic                              Busy;

    // Skew register side drives requests and observes results.
    modport master (
        output Skew, Update,
        input  Y1, Y2, Y3, Valid, Done, Busy
    );

    // Scheduler side.
    modport slave (
        input  Skew, Update,
        output Y1, Y2, Y3, Valid, Done, Busy
    );

endinterface

// File: rtl/dds_recip_div.sv
// Bit-serial reciprocal: q = largest 18-bit value with den*q < 2^27, one bit per cycle MSB-first.
// The first quotient bit is resolved on the start edge, so q is final 18 edges after start and
// done is visible in the following cycle; q then holds until the next start.
module dds_recip_div
    import dds_pkg::*;
(
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic                   start,
    input  logic [DDS_CONST_W-1:0] den,
    output logic [DDS_CONST_W-1:0] q,
    output logic                   done
);

    localparam int unsigned AccW = 2 * DDS_CONST_W;

    logic [AccW-1:0]        acc_q, acc_cur;   // den * (quotient bits accepted so far)
    logic [AccW-1:0]        ds_q, ds_cur;     // den weighted by the bit under test
    logic [AccW-1:0]        trial;
    logic [DDS_CONST_W-1:0] q_q, q_cur;
    logic [4:0]             cnt_q;
    logic                   done_q;
    logic                   step;
    logic                   take;

    // Restoring trial: accept the bit if the running product stays below the limit.
    always_comb begin
        step    = start || (cnt_q != '0);
        acc_cur = start ? '0 : acc_q;
        ds_cur  = start ? ({{(AccW-DDS_CONST_W){1'b0}}, den} << (DDS_CONST_W - 1)) : ds_q;
        q_cur   = start ? '0 : q_q;
        trial   = acc_cur + ds_cur;
        take    = (trial >> DDS_NUM_LIMIT_BIT) == '0;
    end

    // Iteration state; a new start overrides any step in progress.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            acc_q  <= '0;
            ds_q   <= '0;
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (step) begin
                acc_q <= take ? trial : acc_cur;
                ds_q  <= ds_cur >> 1;
                q_q   <= {q_cur[DDS_CONST_W-2:0], take};
                cnt_q <= start ? 5'(DDS_CONST_W - 1) : cnt_q - 5'd1;
                if (!start && cnt_q == 5'd1) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign q    = q_q;
    assign done = done_q;

endmodule

// File: rtl/dds_const_sched.sv
// Round-robin scheduler sharing one reciprocal divider across N DDS channels.
// Produces Y1 = D, Y2 = 2^27/D and Y3 = 2^27/(2^18 - D) per channel (saturating, floor).
// Optional: define DDS_SCHED_CHANGE_DETECT_EN to also request recompute on any Skew change.
module dds_const_sched
    import dds_pkg::*;
#(
    parameter int unsigned N  = 12,
    parameter int unsigned CW = 4
) (
    input  logic              Clk,
    input  logic              nReset,
    dds_const_sched_if.slave  bus
);

    dds_state_e                        state_q;
    logic [CW-1:0]                     ptr_q;
    logic [CW-1:0]                     ch_q;
    logic [N-1:0]                      dirty_q, dirty_d;
    logic [N-1:0]                      set_vec;
    logic [DDS_CONST_W-1:0]            d_q;
    logic [DDS_CONST_W-1:0]            q1_q;
    logic [N-1:0][DDS_CONST_W-1:0]     y1_q, y2_q, y3_q;
    logic [N-1:0]                      valid_q;
    logic [N-1:0]                      done_q;
    logic                              busy_q;

    logic                              grant_valid;
    logic [CW-1:0]                     grant_idx;
    logic [CW-1:0]                     cand;
    logic [DDS_SKEW_W-1:0]             skew_sel;
    logic [DDS_CONST_W-1:0]            d_grant;

    logic                              div_start;
    logic [DDS_CONST_W-1:0]            div_den;
    logic [DDS_CONST_W-1:0]            div_q;
    logic                              div_done;

`ifdef DDS_SCHED_CHANGE_DETECT_EN
    logic [DDS_SKEW_W*N-1:0] skew_prev_q;

    // Per-channel copy of Skew, refreshed every cycle.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            skew_prev_q <= '0;
        end else begin
            skew_prev_q <= bus.Skew;
        end
    end

    // Request on Update or any bit change since last cycle.
    always_comb begin
        set_vec = bus.Update;
        for (int i = 0; i < N; i++) begin
            if (bus.Skew[i*DDS_SKEW_W +: DDS_SKEW_W] !=
                skew_prev_q[i*DDS_SKEW_W +: DDS_SKEW_W]) begin
                set_vec[i] = 1'b1;
            end
        end
    end
`else
    assign set_vec = bus.Update;
`endif

    // First dirty channel after ptr_q with wrap; the descending scan leaves the nearest one.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = int'(N); k >= 1; k--) begin
            cand = CW'((int'(ptr_q) + k) % int'(N));
            if (dirty_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Operand of the candidate channel; zero skew maps to 1 to keep the reciprocal defined.
    always_comb begin
        skew_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == grant_idx) begin
                skew_sel = bus.Skew[i*DDS_SKEW_W +: DDS_SKEW_W];
            end
        end
        d_grant = (skew_sel == '0) ? DDS_CONST_W'(1) : {skew_sel, 2'b00};
    end

    // Pending requests: grant clears, a same-cycle request wins over the clear.
    always_comb begin
        dirty_d = dirty_q;
        if (state_q == StIdle && grant_valid) begin
            dirty_d[grant_idx] = 1'b0;
        end
        dirty_d = dirty_d | set_vec;
    end

    // Divider starts on grant (den = D) and again when DIV1 finishes (den = 2^18 - D).
    always_comb begin
        div_start = (state_q == StIdle && grant_valid) || (state_q == StDiv1 && div_done);
        div_den   = (state_q == StIdle) ? d_grant : dds_complement(d_q);
    end

    dds_recip_div u_div (
        .Clk    (Clk),
        .nReset (nReset),
        .start  (div_start),
        .den    (div_den),
        .q      (div_q),
        .done   (div_done)
    );

    // Scheduler FSM with registered outputs; WRITE takes Y3 straight from the held quotient.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q <= StIdle;
            ptr_q   <= CW'(N - 1);
            ch_q    <= '0;
            dirty_q <= '1;
            d_q     <= '0;
            q1_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            valid_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            dirty_q <= dirty_d;
            done_q  <= '0;
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        ch_q    <= grant_idx;
                        ptr_q   <= grant_idx;
                        d_q     <= d_grant;
                        busy_q  <= 1'b1;
                        state_q <= StDiv1;
                    end
                end
                StDiv1: begin
                    if (div_done) begin
                        q1_q    <= div_q;
                        state_q <= StDiv2;
                    end
                end
                StDiv2: begin
                    if (div_done) begin
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    for (int i = 0; i < N; i++) begin
                        if (CW'(i) == ch_q) begin
                            y1_q[i]    <= d_q;
                            y2_q[i]    <= q1_q;
                            y3_q[i]    <= div_q;
                            valid_q[i] <= 1'b1;
                            done_q[i]  <= 1'b1;
                        end
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.Y1    = y1_q;
    assign bus.Y2    = y2_q;
    assign bus.Y3    = y3_q;
    assign bus.Valid = valid_q;
    assign bus.Done  = done_q;
    assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_dds_const_sched.sv
// Scoreboard bench for dds_const_sched: a request-level model predicts grants and constants,
// a negedge monitor checks every Done against the queued predictions.
`timescale 1ns/1ps
module tb_dds_const_sched;
    import dds_pkg::*;

    localparam int unsigned N  = 12;
    localparam int unsigned CW = 4;
    localparam int          GRANT_GAP  = 38;  // grant-to-grant spacing
    localparam int          DONE_DELAY = 37;  // Done visible after edge grant+37

    logic Clk = 1'b0;
    logic nReset = 1'b0;
    always #5 Clk = ~Clk;

    dds_const_sched_if #(.N(N)) bus ();

    dds_const_sched #(.N(N), .CW(CW)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct {
        int          ch;
        int          cyc;
        logic [17:0] y1, y2, y3;
    } exp_t;

    exp_t exp_q[$];
    int   done_order[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   done_seen = 0;

    // Reference model state
    bit                   m_dirty[N];
    logic [15:0]          m_prev[N];
    int                   m_ptr = N - 1;
    int                   m_last_grant = -1000;
    int                   m_last_ch = -1;
    int                   m_grants = 0;
    logic [N-1:0][17:0]   m_y1, m_y2, m_y3;
    logic [N-1:0]         m_valid;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    endtask

    function automatic logic [17:0] recip(input longint den);
        longint q;
        if (den == 0) return 18'h3FFFF;
        q = ((longint'(1) << DDS_NUM_LIMIT_BIT) - 1) / den;
        if (q > 262143) q = 262143;
        return q[17:0];
    endfunction

    function automatic logic [15:0] skew_of(input int c);
        return bus.Skew[c*16 +: 16];
    endfunction

    function automatic bit any_dirty();
        for (int i = 0; i < N; i++) if (m_dirty[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the request-level model.
    task automatic model_step();
        bit          found;
        int          c;
        longint      d;
        logic [15:0] sk;
        exp_t        e;
        if (!nReset) begin
            for (int i = 0; i < N; i++) begin
                m_dirty[i] = 1'b1;
                m_prev[i]  = '0;
            end
            m_y1 = '0; m_y2 = '0; m_y3 = '0; m_valid = '0;
            m_ptr = N - 1;
            m_last_grant = -1000;
            exp_q.delete();
            return;
        end
        found = 1'b0;
        if (cyc >= m_last_grant + GRANT_GAP) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && m_dirty[c]) begin
                    found = 1'b1;
                    m_dirty[c] = 1'b0;
                    m_ptr = c;
                    m_last_grant = cyc;
                    m_last_ch = c;
                    m_grants++;
                    sk = skew_of(c);
                    d = (sk == 0) ? 1 : longint'(sk) * 4;
                    e.ch = c;
                    e.cyc = cyc + DONE_DELAY;
                    e.y1 = d[17:0];
                    e.y2 = recip(d);
                    e.y3 = recip((262144 - d) % 262144);
                    exp_q.push_back(e);
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (bus.Update[i]) m_dirty[i] = 1'b1;
`ifdef DDS_SCHED_CHANGE_DETECT_EN
            if (skew_of(i) != m_prev[i]) m_dirty[i] = 1'b1;
            m_prev[i] = skew_of(i);
`endif
        end
    endtask

    initial begin : model_proc
        forever begin
            @(posedge Clk);
            cyc++;
            model_step();
        end
    end

    initial begin : monitor
        exp_t       e;
        logic [N-1:0] oh;
        bit         exp_busy;
        forever begin
            @(negedge Clk);
            if (cyc >= 1) begin
                exp_busy = (cyc >= m_last_grant) && (cyc <= m_last_grant + DONE_DELAY - 1);
                chk("busy", 256'(bus.Busy), 256'(exp_busy));
                if (bus.Done != '0) begin
                    done_seen++;
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", 256'(bus.Done), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        done_order.push_back(e.ch);
                        oh = '0;
                        oh[e.ch] = 1'b1;
                        chk("done_channel", 256'(bus.Done), 256'(oh));
                        chk("done_cycle", 256'(cyc), 256'(e.cyc));
                        chk("y1_ch", 256'(bus.Y1[e.ch*18 +: 18]), 256'(e.y1));
                        chk("y2_ch", 256'(bus.Y2[e.ch*18 +: 18]), 256'(e.y2));
                        chk("y3_ch", 256'(bus.Y3[e.ch*18 +: 18]), 256'(e.y3));
                        m_y1[e.ch] = e.y1;
                        m_y2[e.ch] = e.y2;
                        m_y3[e.ch] = e.y3;
                        m_valid[e.ch] = 1'b1;
                        chk("y1_all", 256'(bus.Y1), 256'(m_y1));
                        chk("y2_all", 256'(bus.Y2), 256'(m_y2));
                        chk("y3_all", 256'(bus.Y3), 256'(m_y3));
                        chk("valid_all", 256'(bus.Valid), 256'(m_valid));
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    oh = '0;
                    oh[e.ch] = 1'b1;
                    chk("done_missing", 256'(bus.Done), 256'(oh));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic pulse_update(input logic [N-1:0] mask);
        bus.Update = mask;
        tick(1);
        bus.Update = '0;
    endtask

    task automatic set_skew(input int c, input logic [15:0] v);
        bus.Skew[c*16 +: 16] = v;
    endtask

    task automatic drain(input int limit);
        bit idle = 1'b0;
        for (int i = 0; i < limit && !idle; i++) begin
            idle = (exp_q.size() == 0) && !any_dirty() && (cyc >= m_last_grant + GRANT_GAP);
            if (!idle) tick(1);
        end
        chk("drain_pending", 256'(exp_q.size() + int'(any_dirty())), 256'(0));
    endtask

    task automatic wait_grant(input int ch);
        int  snap = m_grants;
        bit  hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            hit = (m_grants != snap) && (m_last_ch == ch);
            if (!hit) tick(1);
        end
        chk("grant_seen", 256'(m_last_ch), 256'(ch));
    endtask

    initial begin : stimulus
        int snap;
        int c;
        logic [15:0] v;
        bus.Skew = '0;
        bus.Update = '0;
        nReset = 1'b0;
        tick(3);
        chk("rst_y1", 256'(bus.Y1), 256'(0));
        chk("rst_y2", 256'(bus.Y2), 256'(0));
        chk("rst_y3", 256'(bus.Y3), 256'(0));
        chk("rst_valid", 256'(bus.Valid), 256'(0));
        chk("rst_done", 256'(bus.Done), 256'(0));
        chk("rst_busy", 256'(bus.Busy), 256'(0));

        // Initial sweep with all-zero skews
        done_order.delete();
        nReset = 1'b1;
        drain(1000);
        chk("sweep_count", 256'(done_order.size()), 256'(N));
        for (int i = 0; i < done_order.size(); i++) chk("sweep_order", 256'(done_order[i]), 256'(i));
        chk("sweep_y1_ch0", 256'(bus.Y1[17:0]), 256'(18'h00001));
        chk("sweep_y2_ch0", 256'(bus.Y2[17:0]), 256'(18'h3FFFF));
        chk("sweep_y3_ch0", 256'(bus.Y3[17:0]), 256'(18'h00200));
        chk("sweep_valid", 256'(bus.Valid), 256'({N{1'b1}}));

        set_skew(3, 16'h4000);
        pulse_update(12'(1 << 3));
        drain(200);
        chk("ch3_y1", 256'(bus.Y1[3*18 +: 18]), 256'(18'h10000));
        chk("ch3_y2", 256'(bus.Y2[3*18 +: 18]), 256'(18'h007FF));
        chk("ch3_y3", 256'(bus.Y3[3*18 +: 18]), 256'(18'h002AA));

        set_skew(5, 16'h8000);
        pulse_update(12'(1 << 5));
        drain(200);
        chk("ch5_y1", 256'(bus.Y1[5*18 +: 18]), 256'(18'h20000));
        chk("ch5_y2", 256'(bus.Y2[5*18 +: 18]), 256'(18'h003FF));
        chk("ch5_y3", 256'(bus.Y3[5*18 +: 18]), 256'(18'h003FF));

        // Round-robin from pointer 9, plus a re-request during a channel's own DIV1
        done_order.delete();
        set_skew(9, 16'(($urandom % 65535) + 1));
        pulse_update(12'(1 << 9));
        tick(5);
        set_skew(2, 16'(($urandom % 65535) + 1));
        set_skew(7, 16'(($urandom % 65535) + 1));
        pulse_update(12'((1 << 2) | (1 << 7)));
        wait_grant(2);
        tick(3);
        pulse_update(12'(1 << 2));
        drain(400);
        chk("rr_count", 256'(done_order.size()), 256'(4));
        if (done_order.size() == 4) begin
            chk("rr_first", 256'(done_order[0]), 256'(9));
            chk("rr_second", 256'(done_order[1]), 256'(2));
            chk("rr_third", 256'(done_order[2]), 256'(7));
            chk("rr_fourth", 256'(done_order[3]), 256'(2));
        end

        // Reset ten cycles into DIV2
        set_skew(1, 16'h1234);
        pulse_update(12'(1 << 1));
        wait_grant(1);
        tick(27);
        snap = done_seen;
        nReset = 1'b0;
        tick(2);
        chk("abort_valid", 256'(bus.Valid), 256'(0));
        chk("abort_y1", 256'(bus.Y1), 256'(0));
        chk("abort_busy", 256'(bus.Busy), 256'(0));
        chk("abort_no_done", 256'(done_seen), 256'(snap));
        done_order.delete();
        nReset = 1'b1;
        drain(1000);
        chk("resweep_count", 256'(done_order.size()), 256'(N));

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            c = int'($urandom_range(0, N - 1));
            v = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            set_skew(c, v);
            if ($urandom_range(0, 3) != 0) pulse_update(12'(1 << c));
            else tick(1);
            tick(int'($urandom_range(0, 50)));
        end
        drain(1000);

        // Skew change with Update held low
        snap = done_seen;
        set_skew(0, ~skew_of(0));
        tick(100);
`ifdef DDS_SCHED_CHANGE_DETECT_EN
        chk("change_detect_done", 256'(done_seen - snap), 256'(1));
`else
        chk("change_no_done", 256'(done_seen - snap), 256'(0));
`endif
        drain(200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dds_const_sched.md
Name: dds_const_sched

Overview:
- Shares one bit-serial reciprocal divider between N DDS channels and produces each channel's skew constants: Y1 (skew), Y2 (1/skew) and Y3 (1/(2^18 - skew)).
- Each channel requests recomputation with an Update strobe or through skew change detection. The block grants pending channels in round-robin order and writes results only for the granted channel.
- Sits between the skew control registers and the DDS phase-shaping datapaths.

Parameters:
- N, 12, number of channels (1..16).
- CW, 4, channel index width; must satisfy 2^CW >= N.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- nReset  in  1  synchronous, active-low reset.
- Skew  in  16*N  per-channel skew; channel i occupies [16i+15:16i].
- Update  in  N  per-channel recompute request; high for one or more cycles.
- Y1  out  18*N  per-channel operand; channel i occupies [18i+17:18i].
- Y2  out  18*N  per-channel reciprocal of operand.
- Y3  out  18*N  per-channel reciprocal of (2^18 - operand).
- Valid  out  N  Y1/Y2/Y3 of the channel hold a completed result.
- Done  out  N  one-cycle pulse when the channel's results are written.
- Busy  out  1  divider engaged (state not IDLE).

Behaviour:
- Reset (nReset low at a rising edge): Y1/Y2/Y3 = 0, Valid = 0, Done = 0, Busy = 0, state = IDLE, round-robin pointer = N-1, Dirty = all ones, captured skews = 0.
- Reset asserted mid-computation aborts the computation; nothing is written.
- Dirty[i] is set by Update[i]. Dirty[i] is cleared only when channel i is granted. If a set and a clear fall in the same cycle, the set wins, so the channel is recomputed later.
- Operand for a grant: D = {Skew_i, 2'b00}. If Skew_i == 0, D = 18'h00001.
- Division rule: q is the largest 18-bit value with den*q < 2^27 (36-bit product). The result saturates at 18'h3FFFF.
  - Computed MSB-first as a restoring bit search, one quotient bit per cycle, 18 cycles.
  - Y2 uses den = D.
  - Y3 uses den = (2^18 - D) mod 2^18.
- State machine:
  - IDLE: if any Dirty bit is set, grant the first set bit searching from pointer+1 with wrap-around. On grant: latch channel index, latch D, clear its Dirty bit, move pointer to the granted index, go to DIV1.
  - DIV1: 18 cycles, result held in Q1, then go to DIV2.
  - DIV2: 18 cycles, result held in Q2, then go to WRITE.
  - WRITE: write Y1_i = D, Y2_i = Q1, Y3_i = Q2; set Valid[i]; go to IDLE.
- Timing: Done[i] pulses in the cycle after WRITE. Grant-to-Done latency is 38 cycles. Back-to-back grants are 38 cycles apart.
- Outputs of non-granted channels never change.
- A Skew change after D is latched does not affect the current computation. It is picked up through Dirty.
- Valid[i] stays set once set, until reset.
- Busy is high in DIV1, DIV2 and WRITE.

Optional Feature:
- Macro: DDS_SCHED_CHANGE_DETECT_EN.
- Defined: the block keeps a registered copy of each Skew_i, updated every cycle. Any bit difference between Skew_i and its copy sets Dirty[i], OR'ed with Update[i].
- Undefined: no per-channel copies; Dirty is set by Update only.

Decomposition:
- Shared package dds_pkg holds:
  - DDS_CONST_W = 18 and DDS_SKEW_W = 16;
  - DDS_NUM_LIMIT_BIT = 27;
  - the state enum {IDLE, DIV1, DIV2, WRITE};
  - the function computing 2^18-complement of the operand.
- Sub-module dds_recip_div: start/den in, 18-cycle bit-serial restoring search, q/done out. Instantiated once and reused for DIV1 and DIV2.

Test Plan:
- Release reset with all Skew = 0 and N = 12:
  - Done pulses in channel order 0..11, 38 cycles apart;
  - each channel gets Y1 = 18'h00001, Y2 = 18'h3FFFF, Y3 = 18'h00200.
- Skew_3 = 16'h4000, Update[3] pulse → Y1_3 = 18'h10000, Y2_3 = 18'h007FF, Y3_3 = 18'h002AA, Done[3] 38 cycles after grant.
- Skew_5 = 16'h8000, Update[5] → Y1_5 = 18'h20000, Y2_5 = 18'h003FF, Y3_5 = 18'h003FF.
- Update[2] and Update[7] in the same cycle while channel 9 is computing, pointer = 9 → grants in order 2 then 7. Re-pulsing Update[2] during its own DIV1 yields a second computation of channel 2.
- Assert nReset 10 cycles into DIV2 → no Y write, no Done, Valid = 0, and a full recompute sweep follows.
- With DDS_SCHED_CHANGE_DETECT_EN defined: change Skew_0 with Update low → channel 0 recomputes. Without the macro → no grant occurs.
